// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one synchronous SRAM between two requesters,
// with per-port lock, registered SRAM command lines and a 2-stage read-return tag pipe.
module sram_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Req0,
  input  logic              Req1,
  input  logic              Wr0,
  input  logic              Wr1,
  input  logic [ADDR_W-1:0] Addr0,
  input  logic [ADDR_W-1:0] Addr1,
  input  logic [DATA_W-1:0] WData0,
  input  logic [DATA_W-1:0] WData1,
  input  logic              Lock0,
  input  logic              Lock1,
  output logic              Gnt0,
  output logic              Gnt1,
  output logic              RValid0,
  output logic              RValid1,
  output logic [DATA_W-1:0] RData0,
  output logic [DATA_W-1:0] RData1,
  output logic [ADDR_W-1:0] Address,
  output logic              ReadEnable,
  output logic              WriteEnable,
  output logic [DATA_W-1:0] DataIN,
  input  logic [DATA_W-1:0] DataOut
);

  typedef enum logic [1:0] {ST_IDLE, ST_LOCK0, ST_LOCK1} state_t;

  state_t state_q, state_d;
  logic   prio_q, prio_d;
  logic   xfer0, xfer1, xfer, xfer_wr;
  logic   rd_vld1_q, rd_port1_q, rd_vld2_q, rd_port2_q;
  logic [ADDR_W-1:0] xfer_addr;
  logic [DATA_W-1:0] xfer_wdata;

  // State register
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic. While locked, a request always wins a grant, so any
  // cycle with the lock bit dropped is either the final transfer or an idle unlock.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (xfer0 && Lock0)      state_d = ST_LOCK0;
        else if (xfer1 && Lock1) state_d = ST_LOCK1;
      end
      ST_LOCK0: if (!Lock0) state_d = ST_IDLE;
      ST_LOCK1: if (!Lock1) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Grant outputs; held low for the whole time reset is asserted
  always_comb begin
    Gnt0 = 1'b0;
    Gnt1 = 1'b0;
    if (Reset) begin
      case (state_q)
        ST_IDLE: begin
          if (Req0 && (!Req1 || !prio_q)) Gnt0 = 1'b1;
          else if (Req1)                  Gnt1 = 1'b1;
        end
        ST_LOCK0: Gnt0 = Req0;
        ST_LOCK1: Gnt1 = Req1;
        default: ;
      endcase
    end
  end

  assign xfer0      = Req0 & Gnt0;
  assign xfer1      = Req1 & Gnt1;
  assign xfer       = xfer0 | xfer1;
  assign xfer_wr    = xfer1 ? Wr1 : Wr0;
  assign xfer_addr  = xfer1 ? Addr1 : Addr0;
  assign xfer_wdata = xfer1 ? WData1 : WData0;

  always_comb begin
    prio_d = prio_q;
    if (xfer0)      prio_d = 1'b1;
    else if (xfer1) prio_d = 1'b0;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      prio_q      <= 1'b0;
      Address     <= '0;
      ReadEnable  <= 1'b0;
      WriteEnable <= 1'b0;
      DataIN      <= '0;
      rd_vld1_q   <= 1'b0;
      rd_port1_q  <= 1'b0;
      rd_vld2_q   <= 1'b0;
      rd_port2_q  <= 1'b0;
    end else begin
      prio_q      <= prio_d;
      ReadEnable  <= xfer & ~xfer_wr;
      WriteEnable <= xfer & xfer_wr;
      if (xfer) Address <= xfer_addr;
      if (xfer && xfer_wr) DataIN <= xfer_wdata;
      // Stage 1 tracks the SRAM command cycle, stage 2 the data-return cycle
      rd_vld1_q  <= xfer & ~xfer_wr;
      rd_port1_q <= xfer1;
      rd_vld2_q  <= rd_vld1_q;
      rd_port2_q <= rd_port1_q;
    end
  end

  assign RValid0 = rd_vld2_q & ~rd_port2_q;
  assign RValid1 = rd_vld2_q & rd_port2_q;
  assign RData0  = DataOut;
  assign RData1  = DataOut;

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: stimulus pushes expected read returns,
// a monitor forked alongside pops and compares them at each falling edge.
module tb_sram_arbiter;
  localparam int AW = 5;
  localparam int DW = 16;

  logic          Clock = 1'b0;
  logic          Reset = 1'b0;
  logic          Req0, Req1, Wr0, Wr1, Lock0, Lock1;
  logic [AW-1:0] Addr0, Addr1;
  logic [DW-1:0] WData0, WData1;
  logic          Gnt0, Gnt1, RValid0, RValid1;
  logic [DW-1:0] RData0, RData1;
  logic [AW-1:0] Address;
  logic          ReadEnable, WriteEnable;
  logic [DW-1:0] DataIN;
  logic [DW-1:0] DataOut = '0;

  always #5 Clock = ~Clock;

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .Clock(Clock), .Reset(Reset),
    .Req0(Req0), .Req1(Req1), .Wr0(Wr0), .Wr1(Wr1),
    .Addr0(Addr0), .Addr1(Addr1), .WData0(WData0), .WData1(WData1),
    .Lock0(Lock0), .Lock1(Lock1), .Gnt0(Gnt0), .Gnt1(Gnt1),
    .RValid0(RValid0), .RValid1(RValid1), .RData0(RData0), .RData1(RData1),
    .Address(Address), .ReadEnable(ReadEnable), .WriteEnable(WriteEnable),
    .DataIN(DataIN), .DataOut(DataOut)
  );

  // SRAM model, preloaded on the first edge (reset is active then)
  logic [DW-1:0] mem [32];
  bit booted = 1'b0;
  always @(posedge Clock) begin
    if (!booted) begin
      mem[7]  <= 16'h1234;
      mem[8]  <= 16'h5678;
      booted  <= 1'b1;
    end else begin
      if (WriteEnable) mem[Address] <= DataIN;
      if (ReadEnable)  DataOut <= mem[Address];
    end
  end

  typedef struct {
    logic          port;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t          sb_q[$];
  logic [DW-1:0] exp_mem [32];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge Clock);
      cyc++;
      chk("re_we_exclusive", 32'(ReadEnable & WriteEnable), 32'd0);
      if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
        e = sb_q.pop_front();
        chk("rvalid0", 32'(RValid0), 32'(!e.port));
        chk("rvalid1", 32'(RValid1), 32'(e.port));
        chk("rdata", 32'(e.port ? RData1 : RData0), 32'(e.data));
      end else begin
        chk("rvalid0_idle", 32'(RValid0), 32'd0);
        chk("rvalid1_idle", 32'(RValid1), 32'd0);
      end
    end
  endtask

  // g: expected granted port this cycle, -1 for none
  task automatic step(input int g, input string name);
    logic          wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    @(negedge Clock);
    chk({name, "_gnt0"}, 32'(Gnt0), 32'(g == 0));
    chk({name, "_gnt1"}, 32'(Gnt1), 32'(g == 1));
    @(posedge Clock);
    if (g >= 0) begin
      wr = (g == 1) ? Wr1 : Wr0;
      a  = (g == 1) ? Addr1 : Addr0;
      d  = (g == 1) ? WData1 : WData0;
      if (wr) exp_mem[a] = d;
      else    sb_q.push_back('{port: (g == 1), data: exp_mem[a], due: cyc + 2});
    end
    #1;
  endtask

  task automatic stimulus();
    int fair [6] = '{0, 1, 0, 1, 0, 1};
    exp_mem[7] = 16'h1234;
    exp_mem[8] = 16'h5678;
    Req0 = 1'b1; Req1 = 1'b1; Wr0 = 1'b0; Wr1 = 1'b0;
    Addr0 = 5'd7; Addr1 = 5'd8; WData0 = '0; WData1 = '0;
    Lock0 = 1'b0; Lock1 = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    chk("rst_gnt0", 32'(Gnt0), 32'd0);
    chk("rst_gnt1", 32'(Gnt1), 32'd0);
    chk("rst_re", 32'(ReadEnable), 32'd0);
    chk("rst_we", 32'(WriteEnable), 32'd0);
    chk("rst_addr", 32'(Address), 32'd0);
    chk("rst_din", 32'(DataIN), 32'd0);

    Reset = 1'b1;
    step(0, "release");
    chk("rd7_re", 32'(ReadEnable), 32'd1);
    chk("rd7_we", 32'(WriteEnable), 32'd0);
    chk("rd7_addr", 32'(Address), 32'd7);
    Req0 = 1'b0;
    step(1, "p1_read");

    Req0 = 1'b1;
    foreach (fair[k]) step(fair[k], "fair");

    // Port 1 locked write burst with port 0 waiting
    Req0 = 1'b0; Req1 = 1'b1; Wr1 = 1'b1; Lock1 = 1'b1;
    Addr1 = 5'd24; WData1 = 16'hA024;
    step(1, "lock_w24");
    Req0 = 1'b1; Addr0 = 5'd25;
    Addr1 = 5'd25; WData1 = 16'hA025;
    step(1, "lock_w25");
    Req1 = 1'b0;
    step(-1, "lock_idle");
    Req1 = 1'b1; Addr1 = 5'd26; WData1 = 16'hA026;
    step(1, "lock_w26");
    Addr1 = 5'd27; WData1 = 16'hA027; Lock1 = 1'b0;
    step(1, "lock_w27");
    Req1 = 1'b0; Wr1 = 1'b0;
    step(0, "unlock_r25");
    Addr0 = 5'd24; step(0, "r24");
    Addr0 = 5'd26; step(0, "r26");
    Addr0 = 5'd27; step(0, "r27");

    // Write then read of the same address on the following cycle
    Wr0 = 1'b1; Addr0 = 5'd15; WData0 = 16'hBEEF;
    step(0, "w15");
    Req0 = 1'b0; Wr0 = 1'b0; Req1 = 1'b1; Addr1 = 5'd15;
    step(1, "r15");
    Req1 = 1'b0;
    repeat (3) step(-1, "drain");

    // Reset between acceptance and return of a read
    Req0 = 1'b1; Addr0 = 5'd7;
    step(0, "rd_before_rst");
    chk("pre_rst_re", 32'(ReadEnable), 32'd1);
    Req1 = 1'b1;
    #2;
    Reset = 1'b0;
    sb_q.delete();
    #1;
    chk("mid_rst_re", 32'(ReadEnable), 32'd0);
    chk("mid_rst_addr", 32'(Address), 32'd0);
    chk("mid_rst_gnt0", 32'(Gnt0), 32'd0);
    chk("mid_rst_gnt1", 32'(Gnt1), 32'd0);
    repeat (2) @(posedge Clock);
    #1;
    Reset = 1'b1;
    step(0, "post_rst_first");
    Req0 = 1'b0; Req1 = 1'b0;
    repeat (4) step(-1, "final_drain");
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    fork
      monitor();
      stimulus();
    join_any
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port round-robin arbiter that shares the single 32x16 synchronous SRAM between two requesters, e.g. the block-processing datapath and a host/loader port. It accepts one access per cycle using a Req/Gnt handshake and drives the SRAM command lines (`Address`, `ReadEnable`, `WriteEnable`, `DataIN`) from registers. It returns read data to the originating port with a valid strobe. An optional per-port lock gives one requester exclusive ownership across a multi-access sequence, such as reading a block and then writing its result.

## Interface
- `ADDR_W`, 5, SRAM address width (32 words)
- `DATA_W`, 16, SRAM word width
- `Clock` in 1: single clock; all state changes on its rising edge
- `Reset` in 1: asynchronous, active-low reset
- `Req0`/`Req1` in 1: port requests an access
- `Wr0`/`Wr1` in 1: 1 = write, 0 = read; qualified by `Req`
- `Addr0`/`Addr1` in `ADDR_W`: access address
- `WData0`/`WData1` in `DATA_W`: write data
- `Lock0`/`Lock1` in 1: hold ownership after the current transfer
- `Gnt0`/`Gnt1` out 1: request accepted at this rising edge (combinational)
- `RValid0`/`RValid1` out 1: read data valid for this port, one-cycle pulse
- `RData0`/`RData1` out `DATA_W`: read data; equals `DataOut`, meaningful only while `RValid` is 1
- `Address` out `ADDR_W`: SRAM address (registered)
- `ReadEnable` out 1: SRAM read strobe (registered)
- `WriteEnable` out 1: SRAM write strobe (registered)
- `DataIN` out `DATA_W`: write data to the SRAM (registered)
- `DataOut` in `DATA_W`: SRAM read data; updated at the edge that samples `ReadEnable`

## Operation
- **Transfer rule.** A transfer on port i occurs at a rising edge where `Req_i`=1 and `Gnt_i`=1.
  - At most one `Gnt` is 1 per cycle.
  - Requesters must hold `Wr`, `Addr` and `WData` stable while `Req` is 1 and `Gnt` is 0.
- **Round-robin.** A 1-bit priority pointer `prio` names the preferred port; it resets to 0.
  - Only one port requesting: that port is granted.
  - Both ports requesting: port `prio` is granted.
  - After each transfer, `prio` becomes the other port.
- **Lock.**
  - Setting the lock: if `Lock_i`=1 at a transfer edge for port i, the arbiter enters LOCKED(i).
  - While LOCKED(i): only port i can be granted; the other port's `Gnt` is forced to 0 even if port i is idle.
  - Leaving LOCKED(i): at the first transfer edge of port i with `Lock_i`=0, or at any edge where `Req_i`=0 and `Lock_i`=0.
  - `prio` is still toggled at each transfer during LOCKED but has no effect until unlock.
- **States.** IDLE/RR (arbitrating) and LOCKED0/LOCKED1, with the transitions listed above.
- **Command register.** Loaded at each transfer edge with `Address`=`Addr_i`.
  - Read transfer: `ReadEnable`=1.
  - Write transfer: `WriteEnable`=1 and `DataIN`=`WData_i`.
  - No transfer: `ReadEnable`=`WriteEnable`=0. `Address` and `DataIN` hold their values.
  - `ReadEnable` and `WriteEnable` are never both 1.
- **Read return.** A 2-stage tag pipeline (valid, port id) follows every read. `RValid_port` pulses in the cycle after the SRAM samples `ReadEnable`.
- **Ordering.** Accesses reach the SRAM in acceptance order, so a read accepted after a write to the same address returns the new data.

## Timing
- **Read latency.**
  - Accept at edge E0.
  - `ReadEnable`/`Address` are valid in cycle E0..E1.
  - The SRAM updates `DataOut` at E1.
  - `RValid_i`=1 with `RData_i` in cycle E1..E2.
  - Total: 2 cycles from acceptance.
- **Write latency.** Accept at E0, and the SRAM writes at E1.
- **Throughput.** One transfer per cycle, with back-to-back reads and writes in any mix. Two ports requesting continuously alternate 0,1,0,1.
- **`Gnt` path.** `Gnt` depends combinationally on `Req`, `prio` and the lock state. Requesters must not drive `Req` combinationally from `Gnt`.
- **Reset values (`Reset`=0, asynchronous).**
  - `ReadEnable`=0, `WriteEnable`=0, `Address`=0, `DataIN`=0.
  - `RValid0`=`RValid1`=0 and the tag pipeline is cleared.
  - `prio`=0, state=IDLE.
  - `Gnt0`=`Gnt1`=0 for as long as `Reset` is 0.
- **Reset mid-operation.** In-flight reads are discarded, and no `RValid` is issued after release. The first grant after release goes to port 0 if both ports request.

## Test plan
- **Reset:** drive `Reset`=0 with both `Req`=1 → all outputs 0 and no `Gnt`. Release → `Gnt0`=1 in the first cycle.
- **Single read:** preload sram[7]=16'h1234; port 0 reads address 7 → `ReadEnable`=1 with `Address`=7 one cycle after accept; `RValid0`=1, `RData0`=16'h1234 two cycles after accept; `RValid1` stays 0.
- **Fairness:** both ports request continuously for 6 transfers → grants 0,1,0,1,0,1 and `prio` alternates.
- **Lock:** port 1 writes addresses 24..27 with `Lock1`=1 on the first 3 and 0 on the 4th, while port 0 requests throughout → `Gnt0`=0 for those 4 cycles, then `Gnt0`=1 on the next cycle; sram[24..27] hold the written data.
- **Write-then-read ordering:** port 0 writes address 15 = 16'hBEEF and port 1 reads address 15 on the next cycle → `RValid1` with 16'hBEEF.
- **Reset during read:** pulse `Reset` low between acceptance and `RValid` → no `RValid` after release; `ReadEnable`=0 immediately when `Reset` falls.
